seg_scan_reader: RTL
====================

// Module: seg_scan_reader
// PURPOSE
//  Inverse of the hex->7-segment decoders. Watches a time-multiplexed seven-segment display bus
//  (one-hot active-low anode select plus segment lines) and recovers the displayed hex digits.
//  Debounces each digit dwell, decodes the segment pattern back to a nibble and assembles a frame.
//  Publishes each completed frame. Used as a self-check monitor beside the display scanner and as the input stage of lab rigs.
// PARAMETERS
//  NDIG        8   number of multiplexed digits (anode lines), 2..8
//  STABLE_CYC  4   consecutive unchanged sampled cycles required before a dwell is captured, >=2
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  an_in        in   NDIG     anode select, active-low, one-hot low; an_in[i]=0 -> digit i shown
//  seg_in       in   7        segments, active-high; bit0=a ... bit6=g
//  value        out  4*NDIG   last complete frame; digit i in value[4*i+3:4*i]
//  blank_mask   out  NDIG     last frame: bit i=1 if digit i was blank (seg=0)
//  frame_valid  out  1        1-cycle pulse when value/blank_mask update
//  err          out  1        1-cycle pulse on illegal pattern or illegal anode code
//  err_code     out  2        01 illegal segment pattern, 10 >1 anode low; held until next err
// BEHAVIOUR
//  Reset (clk edge with rst=1): value=0, blank_mask=0, frame_valid=0, err=0, err_code=00,
//   seen mask=0, stable count=0, FSM=IDLE. Reset mid-frame discards the partial frame.
//  Input stage: an_in/seg_in registered every cycle (s_an, s_seg); stable count increments when
//   the new sample equals the previous one, else clears to 0 (saturates at STABLE_CYC).
//  FSM states:
//   IDLE   : s_an all-ones (blanking) -> stay; any low anode -> SETTLE.
//   SETTLE : input change -> stay, count restarts; count reaches STABLE_CYC-1 -> CHECK.
//   CHECK  : one cycle. >1 anode low -> err pulse, err_code=10, no capture, -> HOLD.
//            Otherwise, for the low digit i: seg=0 -> blank (nibble 0, blank bit 1); legal hex -> nibble;
//            else err pulse, err_code=01, digit i still marked seen with nibble 0, blank bit 0.
//            Write digit to the shadow frame, set seen[i], -> HOLD.
//   HOLD   : wait for input change; change -> IDLE if all anodes high, else SETTLE.
//  Exactly one capture per dwell however long it lasts; a dwell shorter than STABLE_CYC cycles
//   is never captured (glitch/ghost rejection).
//  Latency: inputs constant from edge k -> capture state CHECK at edge k+STABLE_CYC, shadow written
//   at edge k+STABLE_CYC+1.
//  Legal patterns (seg hex -> nibble): 3F0 061 5B2 4F3 664 6D5 7D6 077 7F8 6F9 77A 7Cb 39C 5Ed 79E 71F.
//  Frame: when the capture sets the last clear bit of seen[NDIG-1:0], on the same edge copy shadow
//   (including this digit) to value/blank_mask, pulse frame_valid, clear seen.
//   Re-capture of an already-seen digit before completion overwrites its shadow entry.
//  err and frame_valid may pulse in the same cycle (illegal pattern completing a frame).
//  err_code retains last code; cleared only by rst.
// TESTING
//  1 rst high 2 cycles -> value=0, blank_mask=0, frame_valid=0, err=0, err_code=00.
//  2 scan digits i=0..7 showing nibble (8-i), dwell 10 cycles each -> single frame_valid pulse
//    one cycle after digit7 capture; value=32'h12345678, blank_mask=0.
//  3 as 2 but digit3 dwell 3 cycles (STABLE_CYC=4) then digit3 rescanned at 10 cycles ->
//    no capture of short dwell; frame completes only after rescan; value correct.
//  4 digit 5 shows seg=7'h49 -> err pulse, err_code=01; frame completes with nibble5=0, blank bit5=0.
//  5 an_in=8'b1111_1100 held 10 cycles -> err pulse, err_code=10, seen unchanged, no frame_valid.
//  6 capture digits 0..4, pulse rst, then full frame with digit2 seg=0 -> exactly one frame_valid,
//    blank_mask=8'h04, partial pre-reset digits not present.

Source files
------------

// File: rtl/seg_scan_reader.sv
// Recovers hex digits from a multiplexed seven-segment display bus: debounces each digit
// dwell, decodes the segment pattern back to a nibble and publishes complete frames.
module seg_scan_reader #(
  parameter int unsigned NDIG       = 8,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NDIG-1:0]     an_in,
  input  logic [6:0]          seg_in,
  output logic [4*NDIG-1:0]   value,
  output logic [NDIG-1:0]     blank_mask,
  output logic                frame_valid,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned ZW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                r_state;
  logic [NDIG-1:0]       r_s_an;
  logic [6:0]            r_s_seg;
  logic [CW-1:0]         r_cnt;
  logic [NDIG-1:0]       r_cap_an;
  logic [6:0]            r_cap_seg;
  logic [NDIG-1:0]       r_seen;
  logic [4*NDIG-1:0]     r_sh_val;
  logic [NDIG-1:0]       r_sh_blk;

  logic [ZW-1:0]         w_zeros;
  logic [IW-1:0]         w_idx;
  logic [4:0]            w_dec;
  logic                  w_blank;
  logic                  w_legal;
  logic [3:0]            w_nib;
  logic [NDIG-1:0]       w_seen_next;
  logic                  w_all_seen;
  logic [4*NDIG-1:0]     w_val_next;
  logic [NDIG-1:0]       w_blk_next;
  logic                  w_cap_changed;

  // Segment pattern -> {legal, nibble}; blank (all-off) is handled separately.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'b0_0000;
    endcase
  endfunction

  // Input sampling and stability counter (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_an  <= '1;
      r_s_seg <= '0;
      r_cnt   <= '0;
    end else begin
      r_s_an  <= an_in;
      r_s_seg <= seg_in;
      if ({an_in, seg_in} == {r_s_an, r_s_seg}) begin
        if (r_cnt < CW'(STABLE_CYC))
          r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Decode of the captured dwell and the shadow frame it would produce.
  always_comb begin
    w_zeros = '0;
    w_idx   = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (!r_cap_an[i]) begin
        w_zeros = w_zeros + ZW'(1);
        w_idx   = IW'(i);
      end
    end
    w_dec   = seg_decode(r_cap_seg);
    w_blank = (r_cap_seg == 7'h00);
    w_legal = w_blank | w_dec[4];
    w_nib   = (w_blank || !w_dec[4]) ? 4'h0 : w_dec[3:0];

    w_seen_next = r_seen;
    w_val_next  = r_sh_val;
    w_blk_next  = r_sh_blk;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (IW'(i) == w_idx) begin
        w_seen_next[i]      = 1'b1;
        w_val_next[4*i +: 4] = w_nib;
        w_blk_next[i]       = w_blank;
      end
    end
    w_all_seen    = &w_seen_next;
    w_cap_changed = ({r_s_an, r_s_seg} != {r_cap_an, r_cap_seg});
  end

  // Dwell FSM with registered outputs; one capture per stable dwell.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cap_an    <= '1;
      r_cap_seg   <= '0;
      r_seen      <= '0;
      r_sh_val    <= '0;
      r_sh_blk    <= '0;
      value       <= '0;
      blank_mask  <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!(&r_s_an))
            r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (&r_s_an) begin
            r_state <= S_IDLE;
          end else if (r_cnt >= CW'(STABLE_CYC - 1)) begin
            r_cap_an  <= r_s_an;
            r_cap_seg <= r_s_seg;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_zeros > ZW'(1)) begin
            err      <= 1'b1;
            err_code <= 2'b10;
          end else if (w_zeros == ZW'(1)) begin
            r_sh_val <= w_val_next;
            r_sh_blk <= w_blk_next;
            if (!w_legal) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
            if (w_all_seen) begin
              value       <= w_val_next;
              blank_mask  <= w_blk_next;
              frame_valid <= 1'b1;
              r_seen      <= '0;
            end else begin
              r_seen <= w_seen_next;
            end
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (w_cap_changed)
            r_state <= (&r_s_an) ? S_IDLE : S_SETTLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
